alu_pipe: RTL and testbench

Parametrised, two-stage pipelined ALU that generalises the team's 4-bit combinational ALU to WIDTH bits. It adds registered status flags, optional signed saturation and a valid/ready handshake on both sides, with full backpressure. It sits between the operand-fetch stage and the writeback/accumulate path of the DSP datapath and sustains one operation per clock.

---
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined WIDTH-bit ALU with registered flags, optional
//            signed saturation and valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_INC  = 3'b010;
    localparam logic [2:0] c_OP_PASS = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_OR   = 3'b101;
    localparam logic [2:0] c_OP_XOR  = 3'b110;
    localparam logic [2:0] c_OP_NOT  = 3'b111;

    localparam logic             c_SAT_EN  = SAT_EN;
    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_sat;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [WIDTH-1:0] w_ia;
    logic [WIDTH-1:0] w_ib;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic             w_do_sat;
    logic [WIDTH-1:0] w_res;

    // S2 advances whenever it is empty or being drained; S1 follows S2.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_sat      <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_sat <= sat;
            end
        end
    end

    // Logic ops and pass are routed through the adder with IB=0, Cin=0.
    always_comb begin
        w_ia    = r_a;
        w_ib    = '0;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (r_op)
            c_OP_ADD:  begin w_ib = r_b;  w_arith = 1'b1; end
            c_OP_SUB:  begin w_ib = ~r_b; w_cin = 1'b1; w_arith = 1'b1; end
            c_OP_INC:  begin w_cin = 1'b1; w_arith = 1'b1; end
            c_OP_PASS: w_ia = r_a;
            c_OP_AND:  w_ia = r_a & r_b;
            c_OP_OR:   w_ia = r_a | r_b;
            c_OP_XOR:  w_ia = r_a ^ r_b;
            c_OP_NOT:  w_ia = ~r_a;
            default:   w_ia = r_a;
        endcase
    end

    assign {w_carry, w_sum} = {1'b0, w_ia} + {1'b0, w_ib} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf    = w_arith && (w_ia[WIDTH-1] == w_ib[WIDTH-1])
                              && (w_sum[WIDTH-1] != w_ia[WIDTH-1]);
    assign w_do_sat = c_SAT_EN && r_sat && w_ovf;
    assign w_res    = w_do_sat ? (r_a[WIDTH-1] ? c_SAT_MIN : c_SAT_MAX) : w_sum;

    // Bubbles load zeros so flags never show stale values while out_valid=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_result   <= r_s1_valid ? w_res : '0;
            r_cout     <= r_s1_valid && w_carry;
            r_zero     <= r_s1_valid && (w_res == '0);
            r_neg      <= r_s1_valid && w_res[WIDTH-1];
            r_ovf      <= r_s1_valid && w_ovf;
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (saturating and wrapping builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         sat = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;

    logic         in_ready_s, out_valid_s, cout_s, zero_s, neg_s, ovf_s;
    logic [W-1:0] result_s;
    logic         in_ready_w, out_valid_w, cout_w, zero_w, neg_w, ovf_w;
    logic [W-1:0] result_w;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .sat(sat),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .cout(cout_s), .zero(zero_s), .neg(neg_s), .ovf(ovf_s)
    );

    alu_pipe #(.WIDTH(W), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .sat(sat),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
        .cout(cout_w), .zero(zero_w), .neg(neg_w), .ovf(ovf_w)
    );

    // Expected beat: {result, cout, zero, neg, ovf}; age = edges since acceptance.
    typedef struct {
        logic [W+3:0] es;
        logic [W+3:0] ew;
        int           age;
    } beat_t;

    beat_t q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    bit    saw_block = 1'b0;

    // Reference ALU from plain integer arithmetic.
    function automatic logic [W+3:0] ref_alu(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                             input logic [2:0] fop, input bit fsat, input bit sat_en);
        int           ua, ub, sa, sb, full, sres;
        bit           arith, c, o;
        logic [W-1:0] r;
        ua = int'(fa); ub = int'(fb);
        sa = int'($signed(fa)); sb = int'($signed(fb));
        arith = 1'b1; sres = 0;
        case (fop)
            3'd0: begin full = ua + ub;                 sres = sa + sb; end
            3'd1: begin full = ua + (65535 - ub) + 1;   sres = sa - sb; end
            3'd2: begin full = ua + 1;                  sres = sa + 1;  end
            3'd3: begin full = ua;        arith = 1'b0; end
            3'd4: begin full = ua & ub;   arith = 1'b0; end
            3'd5: begin full = ua | ub;   arith = 1'b0; end
            3'd6: begin full = ua ^ ub;   arith = 1'b0; end
            default: begin full = 65535 - ua; arith = 1'b0; end
        endcase
        c = (full >= 65536);
        r = full[W-1:0];
        o = arith && (sres > 32767 || sres < -32768);
        if (sat_en && fsat && o) r = fa[W-1] ? 16'h8000 : 16'h7FFF;
        return {r, c, (r == 16'h0000), r[W-1], o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check settled outputs, advance model at posedge.
    task automatic cycle(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2:0] iop, input bit isat, input bit ordy, output bit acc);
        bit exp_rdy, exp_ov, con;
        in_valid = iv; a = ia; b = ib; op = iop; sat = isat; out_ready = ordy;
        #1;
        exp_rdy = (q.size() < 2) || ordy;
        exp_ov  = (q.size() > 0) && (q[0].age >= 2);
        if (!in_ready_s) saw_block = 1'b1;
        chk("in_ready_s", {31'd0, in_ready_s}, {31'd0, exp_rdy});
        chk("in_ready_w", {31'd0, in_ready_w}, {31'd0, exp_rdy});
        chk("out_valid_s", {31'd0, out_valid_s}, {31'd0, exp_ov});
        chk("out_valid_w", {31'd0, out_valid_w}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("beat_s", {12'd0, result_s, cout_s, zero_s, neg_s, ovf_s}, {12'd0, q[0].es});
            chk("beat_w", {12'd0, result_w, cout_w, zero_w, neg_w, ovf_w}, {12'd0, q[0].ew});
        end else begin
            chk("zero_idle", {31'd0, zero_s}, 32'd0);
        end
        acc = iv && exp_rdy;
        con = exp_ov && ordy;
        @(posedge clk);
        if (con) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) q.push_back('{ref_alu(ia, ib, iop, isat, 1'b1), ref_alu(ia, ib, iop, isat, 1'b0), 1});
        @(negedge clk);
    endtask

    // Single beat through an idle pipe, checked against hand-computed constants.
    task automatic tp(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] iop, input bit isat,
                      input logic [W+3:0] exp_s, input logic [W+3:0] exp_w);
        bit acc;
        cycle(1'b1, ia, ib, iop, isat, 1'b1, acc);
        cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
        #1;
        chk({tag, "_s"}, {12'd0, result_s, cout_s, zero_s, neg_s, ovf_s}, {12'd0, exp_s});
        chk({tag, "_w"}, {12'd0, result_w, cout_w, zero_w, neg_w, ovf_w}, {12'd0, exp_w});
        cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, acc);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        bit acc;
        int nxt;

        #1;
        chk("rst_out_valid", {31'd0, out_valid_s}, 32'd0);
        chk("rst_flags", {12'd0, result_s, cout_s, zero_s, neg_s, ovf_s}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_s}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        tp("add_wrap",  16'h7FFF, 16'h0001, 3'b000, 1'b0, {16'h8000, 4'b0011}, {16'h8000, 4'b0011});
        tp("add_sat",   16'h7FFF, 16'h0001, 3'b000, 1'b1, {16'h7FFF, 4'b0001}, {16'h8000, 4'b0011});
        tp("add_satn",  16'h8000, 16'hFFFF, 3'b000, 1'b1, {16'h8000, 4'b1011}, {16'h7FFF, 4'b1001});
        tp("sub_zero",  16'h0005, 16'h0005, 3'b001, 1'b0, {16'h0000, 4'b1100}, {16'h0000, 4'b1100});
        tp("not",       16'h00FF, 16'h0000, 3'b111, 1'b0, {16'hFF00, 4'b0010}, {16'hFF00, 4'b0010});

        // Six increments with downstream stalled for cycles 2..5.
        nxt = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 14; c++) begin
            cycle(nxt < 6, W'(nxt), '0, 3'b010, 1'b0, !(c >= 2 && c <= 5), acc);
            if (acc) nxt++;
        end
        chk("stall_blocked", {31'd0, saw_block}, 32'd1);
        chk("stream_all_in", nxt, 6);

        // Two beats in flight, then asynchronous reset between edges.
        cycle(1'b1, 16'h1111, 16'h2222, 3'b000, 1'b0, 1'b0, acc);
        cycle(1'b1, 16'h0001, 16'h0001, 3'b001, 1'b0, 1'b0, acc);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid_s}, 32'd0);
        chk("arst_flags", {12'd0, result_s, cout_s, zero_s, neg_s, ovf_s}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready_s}, 32'd1);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        tp("post_rst", 16'h0003, 16'h0004, 3'b000, 1'b0, {16'h0007, 4'b0000}, {16'h0007, 4'b0000});

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                  3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        for (int c = 0; c < 6; c++) cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, acc);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
